// File: rtl/controle_irrigacao.sv
// Greenhouse irrigation sequencer: timed sprinkler/drip cycle, cooldown, BCD countdown
// for the display multiplexer and tank refill with hysteresis. All outputs are registered.
module controle_irrigacao #(
  parameter int TEMPO_ASPERSAO    = 300,
  parameter int TEMPO_GOTEJAMENTO = 600,
  parameter int TEMPO_ESPERA      = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       umSegundo,
  input  logic       umidadeAr,
  input  logic       umidadeSolo,
  input  logic       temperatura,
  input  logic [2:0] nivelDagua,
  output logic       aspersor,
  output logic       gotejador,
  output logic       valvulaEntrada,
  output logic       alarme,
  output logic [1:0] estado,
  output logic [3:0] dezenaMinuto,
  output logic [3:0] unidadeMinuto,
  output logic [3:0] dezenaSegundos,
  output logic [3:0] unidadeSegundos
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    IRRIGANDO = 2'b01,
    ESPERA    = 2'b10,
    ERRO      = 2'b11
  } estado_t;

  function automatic logic [15:0] paraBcd(input int segundos);
    int mm;
    int ss;
    mm = segundos / 60;
    ss = segundos % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // mm:ss down-count with borrow; 00:00 is sticky.
  function automatic logic [15:0] decrementa(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else if (t[11:8] != 4'd0) begin
      r[11:8] = t[11:8] - 4'd1;
      r[7:0]  = 8'h59;
    end else if (t[15:12] != 4'd0) begin
      r[15:12] = t[15:12] - 4'd1;
      r[11:0]  = 12'h959;
    end
    return r;
  endfunction

  localparam logic [15:0] CARGA_ASP = paraBcd(TEMPO_ASPERSAO);
  localparam logic [15:0] CARGA_GOT = paraBcd(TEMPO_GOTEJAMENTO);
  localparam logic [15:0] CARGA_ESP = paraBcd(TEMPO_ESPERA);
  localparam logic [15:0] UM_SEG    = 16'h0001;

  estado_t     estado_q;
  logic [15:0] timer_q;
  logic        umSegundo_q;
  logic        aspersor_q;
  logic        gotejador_q;
  logic        valvula_q;
  logic        alarme_q;

  logic        tick;
  logic        vazio;
  logic        baixo;
  logic        medio;
  logic        cheio;
  logic        nivelValido;
  logic        modoGot;
  logic        aguaOk;
  logic [15:0] timerMenos;

  assign tick        = umSegundo & ~umSegundo_q;
  assign vazio       = (nivelDagua == 3'b000);
  assign baixo       = (nivelDagua == 3'b001);
  assign medio       = (nivelDagua == 3'b011);
  assign cheio       = (nivelDagua == 3'b111);
  assign nivelValido = vazio | baixo | medio | cheio;
  assign modoGot     = temperatura & ~umidadeAr;
  assign aguaOk      = modoGot ? (baixo | medio | cheio) : (medio | cheio);
  assign timerMenos  = decrementa(timer_q);

  // Invalid level overrides every state; the refill hysteresis runs beside the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      timer_q     <= '0;
      umSegundo_q <= 1'b0;
      aspersor_q  <= 1'b0;
      gotejador_q <= 1'b0;
      valvula_q   <= 1'b0;
      alarme_q    <= 1'b0;
    end else begin
      umSegundo_q <= umSegundo;
      if (!nivelValido) begin
        estado_q    <= ERRO;
        timer_q     <= '0;
        aspersor_q  <= 1'b0;
        gotejador_q <= 1'b0;
        valvula_q   <= 1'b0;
        alarme_q    <= 1'b1;
      end else begin
        if (vazio || baixo) begin
          valvula_q <= 1'b1;
        end else if (cheio) begin
          valvula_q <= 1'b0;
        end
        case (estado_q)
          OCIOSO: begin
            if (!umidadeSolo && aguaOk) begin
              estado_q    <= IRRIGANDO;
              timer_q     <= modoGot ? CARGA_GOT : CARGA_ASP;
              aspersor_q  <= ~modoGot;
              gotejador_q <= modoGot;
              alarme_q    <= 1'b0;
            end else begin
              timer_q  <= '0;
              alarme_q <= ~umidadeSolo;
            end
          end
          IRRIGANDO: begin
            if (vazio || umidadeSolo || (tick && timer_q == UM_SEG)) begin
              estado_q    <= ESPERA;
              timer_q     <= CARGA_ESP;
              aspersor_q  <= 1'b0;
              gotejador_q <= 1'b0;
              if (vazio) begin
                alarme_q <= 1'b1;
              end
            end else if (tick) begin
              timer_q <= timerMenos;
            end
          end
          ESPERA: begin
            if (tick) begin
              if (timer_q == UM_SEG) begin
                estado_q <= OCIOSO;
                timer_q  <= '0;
              end else begin
                timer_q <= timerMenos;
              end
            end
          end
          ERRO: begin
            estado_q <= OCIOSO;
            alarme_q <= 1'b0;
          end
          default: begin
            estado_q <= OCIOSO;
          end
        endcase
      end
    end
  end

  assign estado          = estado_q;
  assign aspersor        = aspersor_q;
  assign gotejador       = gotejador_q;
  assign valvulaEntrada  = valvula_q;
  assign alarme          = alarme_q;
  assign dezenaMinuto    = timer_q[15:12];
  assign unidadeMinuto   = timer_q[11:8];
  assign dezenaSegundos  = timer_q[7:4];
  assign unidadeSegundos = timer_q[3:0];

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao: a short-timer instance for the cycle/refill/error
// behaviour and a 70 s sprinkler instance for the minute borrow and mid-count reset.
module tb_controle_irrigacao;

  logic       clock;
  logic       reset;
  logic       umSegundo;
  logic       umidadeAr;
  logic       umidadeSolo;
  logic       temperatura;
  logic [2:0] nivelDagua;

  logic       aspersor, gotejador, valvulaEntrada, alarme;
  logic [1:0] estado;
  logic [3:0] dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos;

  logic       aspersor70, gotejador70, valvulaEntrada70, alarme70;
  logic [1:0] estado70;
  logic [3:0] dezenaMinuto70, unidadeMinuto70, dezenaSegundos70, unidadeSegundos70;

  logic [15:0] display;
  logic [15:0] display70;

  int errors = 0;
  int checks = 0;

  assign display   = {dezenaMinuto, unidadeMinuto, dezenaSegundos, unidadeSegundos};
  assign display70 = {dezenaMinuto70, unidadeMinuto70, dezenaSegundos70, unidadeSegundos70};

  controle_irrigacao #(
    .TEMPO_ASPERSAO(5), .TEMPO_GOTEJAMENTO(8), .TEMPO_ESPERA(3)
  ) dut (
    .clock(clock), .reset(reset), .umSegundo(umSegundo), .umidadeAr(umidadeAr),
    .umidadeSolo(umidadeSolo), .temperatura(temperatura), .nivelDagua(nivelDagua),
    .aspersor(aspersor), .gotejador(gotejador), .valvulaEntrada(valvulaEntrada),
    .alarme(alarme), .estado(estado), .dezenaMinuto(dezenaMinuto),
    .unidadeMinuto(unidadeMinuto), .dezenaSegundos(dezenaSegundos),
    .unidadeSegundos(unidadeSegundos)
  );

  controle_irrigacao #(
    .TEMPO_ASPERSAO(70), .TEMPO_GOTEJAMENTO(8), .TEMPO_ESPERA(3)
  ) dut70 (
    .clock(clock), .reset(reset), .umSegundo(umSegundo), .umidadeAr(umidadeAr),
    .umidadeSolo(umidadeSolo), .temperatura(temperatura), .nivelDagua(nivelDagua),
    .aspersor(aspersor70), .gotejador(gotejador70), .valvulaEntrada(valvulaEntrada70),
    .alarme(alarme70), .estado(estado70), .dezenaMinuto(dezenaMinuto70),
    .unidadeMinuto(unidadeMinuto70), .dezenaSegundos(dezenaSegundos70),
    .unidadeSegundos(unidadeSegundos70)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n clock edges; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One-cycle pulse on umSegundo; outputs reflect it when this returns.
  task automatic pulse();
    umSegundo = 1'b1;
    applyStimulus(1);
    umSegundo = 1'b0;
  endtask

  task automatic gap();
    applyStimulus(9);
  endtask

  initial begin
    reset = 1'b1; umSegundo = 1'b0; umidadeAr = 1'b0; umidadeSolo = 1'b1;
    temperatura = 1'b0; nivelDagua = 3'b111;
    applyStimulus(2);
    checkOutput("reset_estado", 16'(estado), 16'h0);
    checkOutput("reset_display", display, 16'h0000);
    checkOutput("reset_valves", 16'({aspersor, gotejador, valvulaEntrada, alarme}), 16'h0);

    $display("[TB] sprinkler cycle");
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("idle_moist_alarme", 16'(alarme), 16'h0);
    umidadeSolo = 1'b0;
    applyStimulus(1);
    checkOutput("asp_estado", 16'(estado), 16'h1);
    checkOutput("asp_aspersor", 16'(aspersor), 16'h1);
    checkOutput("asp_gotejador", 16'(gotejador), 16'h0);
    checkOutput("asp_display", display, 16'h0005);
    gap();
    for (int i = 4; i >= 1; i--) begin
      pulse();
      checkOutput("asp_countdown", display, 16'(i));
      gap();
    end
    pulse();
    checkOutput("asp_end_estado", 16'(estado), 16'h2);
    checkOutput("asp_end_aspersor", 16'(aspersor), 16'h0);
    checkOutput("asp_end_display", display, 16'h0003);
    umidadeSolo = 1'b1;
    gap();
    pulse(); gap();
    pulse();
    checkOutput("esp_display", display, 16'h0001);
    checkOutput("esp_ignores_soil", 16'(estado), 16'h2);
    gap();
    pulse();
    checkOutput("esp_end_estado", 16'(estado), 16'h0);
    checkOutput("esp_end_display", display, 16'h0000);
    gap();

    $display("[TB] drip cycle with early stop");
    temperatura = 1'b1; umidadeAr = 1'b0; nivelDagua = 3'b001; umidadeSolo = 1'b0;
    applyStimulus(1);
    checkOutput("got_estado", 16'(estado), 16'h1);
    checkOutput("got_valves", 16'({aspersor, gotejador}), 16'h1);
    checkOutput("got_display", display, 16'h0008);
    checkOutput("got_refill", 16'(valvulaEntrada), 16'h1);
    temperatura = 1'b0;
    gap();
    pulse();
    checkOutput("got_mode_latched", 16'({aspersor, gotejador}), 16'h1);
    checkOutput("got_display7", display, 16'h0007);
    gap();
    pulse(); gap();
    pulse(); gap();
    pulse();
    checkOutput("got_display4", display, 16'h0004);
    umidadeSolo = 1'b1;
    applyStimulus(1);
    checkOutput("early_estado", 16'(estado), 16'h2);
    checkOutput("early_gotejador", 16'(gotejador), 16'h0);
    checkOutput("early_display", display, 16'h0003);
    gap();
    pulse(); gap();
    pulse(); gap();
    pulse();
    checkOutput("early_back_idle", 16'(estado), 16'h0);
    gap();

    $display("[TB] insufficient water and refill hysteresis");
    umidadeSolo = 1'b0; temperatura = 1'b0; umidadeAr = 1'b0; nivelDagua = 3'b001;
    applyStimulus(1);
    checkOutput("low_estado", 16'(estado), 16'h0);
    checkOutput("low_alarme", 16'(alarme), 16'h1);
    checkOutput("low_refill", 16'(valvulaEntrada), 16'h1);
    nivelDagua = 3'b011;
    applyStimulus(1);
    checkOutput("med_estado", 16'(estado), 16'h1);
    checkOutput("med_aspersor", 16'(aspersor), 16'h1);
    checkOutput("med_alarme", 16'(alarme), 16'h0);
    checkOutput("med_refill_hold1", 16'(valvulaEntrada), 16'h1);
    nivelDagua = 3'b111;
    applyStimulus(1);
    checkOutput("full_refill", 16'(valvulaEntrada), 16'h0);
    nivelDagua = 3'b011;
    applyStimulus(1);
    checkOutput("med_refill_hold0", 16'(valvulaEntrada), 16'h0);

    $display("[TB] invalid level");
    nivelDagua = 3'b101;
    applyStimulus(1);
    checkOutput("erro_estado", 16'(estado), 16'h3);
    checkOutput("erro_outputs", 16'({aspersor, gotejador, valvulaEntrada, alarme}), 16'h1);
    checkOutput("erro_display", display, 16'h0000);
    nivelDagua = 3'b111; umidadeSolo = 1'b1;
    applyStimulus(1);
    checkOutput("erro_exit_estado", 16'(estado), 16'h0);
    checkOutput("erro_exit_alarme", 16'(alarme), 16'h0);

    $display("[TB] tank empty while irrigating");
    umidadeSolo = 1'b0;
    applyStimulus(1);
    checkOutput("vz_start", 16'(estado), 16'h1);
    nivelDagua = 3'b000;
    applyStimulus(1);
    checkOutput("vz_estado", 16'(estado), 16'h2);
    checkOutput("vz_outputs", 16'({aspersor, gotejador, valvulaEntrada, alarme}), 16'h3);
    checkOutput("vz_display", display, 16'h0003);

    $display("[TB] 70 s instance, borrow and mid-count reset");
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0; umidadeSolo = 1'b0; temperatura = 1'b0; nivelDagua = 3'b111;
    applyStimulus(1);
    checkOutput("t70_estado", 16'(estado70), 16'h1);
    checkOutput("t70_display", display70, 16'h0110);
    gap();
    umSegundo = 1'b1;
    applyStimulus(5);
    umSegundo = 1'b0;
    checkOutput("t70_level_one_tick", display70, 16'h0109);
    gap();
    for (int i = 0; i < 9; i++) begin
      pulse(); gap();
    end
    checkOutput("t70_display_0100", display70, 16'h0100);
    pulse();
    checkOutput("t70_borrow", display70, 16'h0059);
    applyStimulus(3);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("t70_reset_estado", 16'(estado70), 16'h0);
    checkOutput("t70_reset_display", display70, 16'h0000);
    checkOutput("t70_reset_valves",
                16'({aspersor70, gotejador70, valvulaEntrada70, alarme70}), 16'h0);
    reset = 1'b0;
    applyStimulus(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
